fetch_queue_unit: RTL and testbench

- Parametrised successor to the single-cycle instruction passthrough fetch stage.
- Owns the program counter and issues one-outstanding request/valid reads to instruction memory.
- Buffers returned instruction words (2 bits per trit, 2*WORD_SIZE bits) in a prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports branch redirect with flush and discard of in-flight responses.

---
 rtl/fetch_queue_unit.sv | 127 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: owns the PC, keeps one memory read outstanding and
// buffers returned words in a prefetch FIFO presented to decode via valid/ready.
module fetch_queue_unit #(
    parameter int unsigned WORD_SIZE    = 9,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            fetch_enable,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic                            mem_valid,
    input  logic [2*WORD_SIZE-1:0]          mem_data,
    input  logic                            redirect,
    input  logic [ADDR_WIDTH-1:0]           redirect_addr,
    output logic [2*WORD_SIZE-1:0]          instruction,
    output logic [ADDR_WIDTH-1:0]           instruction_pc,
    output logic                            instruction_valid,
    input  logic                            instruction_ready,
    output logic [$clog2(BUFFER_DEPTH):0]   buffer_count
);

    localparam int unsigned INSTR_W = 2 * WORD_SIZE;
    localparam int unsigned PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]    word;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                fifo [BUFFER_DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    // Redirect cancels both the response push and any decode pop in its cycle.
    assign push = (state == REQUEST) && mem_valid && !redirect;
    assign pop  = (count != '0) && instruction_ready && !redirect;

    assign buffer_count      = count;
    assign instruction_valid = (count != '0);

    always_comb begin
        instruction    = '0;
        instruction_pc = '0;
        if (count != '0) begin
            instruction    = fifo[head].word;
            instruction_pc = fifo[head].pc;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo[tail] <= {mem_data, pc};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= ADDR_WIDTH'(RESET_PC);
            mem_req  <= 1'b0;
            mem_addr <= ADDR_WIDTH'(RESET_PC);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            pc    <= redirect_addr;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // A request already on the bus must still see its response; drop it.
            if (state == REQUEST && !mem_valid) begin
                state <= DISCARD;
            end else if (state != IDLE && mem_valid) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            case (state)
                IDLE: begin
                    // Issue only with a free slot so the response can never overflow.
                    if (fetch_enable && count < CNT_W'(BUFFER_DEPTH)) begin
                        state    <= REQUEST;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                REQUEST: begin
                    if (mem_valid) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        pc      <= pc + ADDR_WIDTH'(1);
                    end
                end
                DISCARD: begin
                    if (mem_valid) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model
// of the fetch rules, including redirects, stray responses and async reset.
module tb_fetch_queue_unit;

    localparam int unsigned WS    = 9;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RPC   = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetch_enable;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic [2*WS-1:0] mem_data;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [2*WS-1:0] instruction;
    logic [AW-1:0] instruction_pc;
    logic          instruction_valid;
    logic          instruction_ready;
    logic [2:0]    buffer_count;

    fetch_queue_unit #(
        .WORD_SIZE(WS), .ADDR_WIDTH(AW), .BUFFER_DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_data(mem_data), .redirect(redirect), .redirect_addr(redirect_addr),
        .instruction(instruction), .instruction_pc(instruction_pc),
        .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
        .buffer_count(buffer_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2*WS-1:0] word;
        logic [AW-1:0]   pc;
    } ent_t;

    // Reference model: a word queue plus "a request is outstanding" and
    // "its response is to be thrown away" flags.
    ent_t          q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_addr;
    bit            m_busy;
    bit            m_drop;
    int unsigned   lat;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = AW'(RPC);
        m_addr = AW'(RPC);
        m_busy = 0;
        m_drop = 0;
        lat    = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_step();
        int  sz;
        bit  do_pop;
        sz     = q.size();
        do_pop = (sz != 0) && instruction_ready;
        if (redirect) begin
            q.delete();
            m_pc = redirect_addr;
            if (m_busy && !mem_valid) m_drop = 1;
            else if (m_busy) begin m_busy = 0; m_drop = 0; end
        end else begin
            if (do_pop) void'(q.pop_front());
            if (m_busy && mem_valid) begin
                if (!m_drop) begin
                    q.push_back('{word: mem_data, pc: m_pc});
                    m_pc = m_pc + 8'd1;
                end
                m_busy = 0;
                m_drop = 0;
            end else if (!m_busy && fetch_enable && sz < int'(DEPTH)) begin
                m_busy = 1;
                m_addr = m_pc;
                lat    = $urandom_range(0, 3);
            end
        end
    endtask

    task automatic compare_outputs();
        check("mem_req", 32'(mem_req), 32'(m_busy));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("buffer_count", 32'(buffer_count), 32'(q.size()));
        check("instruction_valid", 32'(instruction_valid), 32'(q.size() != 0));
        check("instruction", 32'(instruction), (q.size() != 0) ? 32'(q[0].word) : 32'd0);
        check("instruction_pc", 32'(instruction_pc), (q.size() != 0) ? 32'(q[0].pc) : 32'd0);
    endtask

    task automatic choose_inputs(input int cyc);
        int r;
        fetch_enable = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) != 0);
        if (cyc < 40)               instruction_ready = 1'b0;
        else if ((cyc % 200) < 50)  instruction_ready = ($urandom_range(0, 7) == 0);
        else                        instruction_ready = $urandom_range(0, 1) != 0;
        redirect = (cyc >= 40) && ($urandom_range(0, 19) == 0);
        r = $urandom_range(0, 2);
        redirect_addr = (r == 0) ? 8'hFF : (r == 1) ? 8'h40 : AW'($urandom);
        mem_data = (2*WS)'($urandom);
        if (m_busy) begin
            if (lat == 0) mem_valid = 1'b1;
            else begin lat--; mem_valid = 1'b0; end
        end else begin
            mem_valid = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        bit pending_reset;
        reset = 1'b1;
        fetch_enable = 0; mem_valid = 0; mem_data = '0;
        redirect = 0; redirect_addr = '0; instruction_ready = 0;
        model_reset();
        #12;
        compare_outputs();
        reset = 1'b0;
        choose_inputs(0);
        pending_reset = 0;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            @(posedge clock);
            model_step();
            #1;
            compare_outputs();
            if (cyc == 40) check("fill_count", 32'(buffer_count), 32'(DEPTH));
            choose_inputs(cyc);
            if (cyc == 700 || cyc == 1400) pending_reset = 1;
            if (pending_reset && m_busy) begin
                pending_reset = 0;
                #2 reset = 1'b1;
                #1;
                check("rst_mem_req", 32'(mem_req), 32'd0);
                check("rst_count", 32'(buffer_count), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'(RPC));
                check("rst_valid", 32'(instruction_valid), 32'd0);
                #1 reset = 1'b0;
                model_reset();
                mem_valid = 1'b1;
                redirect  = 1'b0;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
